alu_op_decoder: RTL
===================

# alu_op_decoder

Registered instruction-decode stage for the single-cycle RV32I core. It sits between instruction fetch and the execute datapath and turns each 32-bit instruction word into the 4-bit `alucon` operation code the ALU consumes, plus the immediate, operand selects and control strobes. It adds one pipeline register with a valid/ready handshake on each side and supports flush for taken branches.

## Interface
- `RESET_PC_SEL`, default 0: the value `src1_sel` and `src2_sel` take while the block is in reset.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: `in_instr` and `in_pc` are valid.
- `in_ready` output 1: the block can accept an instruction this cycle.
- `in_instr` input 32: instruction word.
- `in_pc` input 32: address of the instruction.
- `flush` input 1: discard all held and incoming instructions.
- `out_valid` output 1: the decoded bundle is valid.
- `out_ready` input 1: the consumer takes the bundle this cycle.
- `alucon` output 4: ALU operation. 0 ADD, 8 SUB, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 13 SRA, 6 OR, 7 AND.
- `imm` output 32: sign-extended immediate (I/S/B/U/J format).
- `src1_sel` output 2: first ALU operand. 0 rs1, 1 pc, 2 zero.
- `src2_sel` output 1: second ALU operand. 0 rs2, 1 imm.
- `rs1`, `rs2`, `rd` output 5 each: register indices.
- `pc_out` output 32: the pc that travels with the instruction.
- `reg_we`, `mem_re`, `mem_we`, `branch`, `jump`, `illegal` output 1 each: control strobes.

## Operation
- `alucon` decode rules:
  - OP (0110011): `{funct7[5], funct3}`.
  - OP-IMM (0010011): `{funct3==5 ? funct7[5] : 0, funct3}`. ADDI never decodes as SUB.
  - LOAD, STORE, JALR: ADD, with `src2_sel` set to imm.
  - AUIPC and JAL: ADD, with `src1_sel` set to pc.
  - LUI: ADD, with `src1_sel` set to zero and `src2_sel` set to imm.
  - BRANCH: BEQ/BNE give SUB (8); BLT/BGE give SLT (2); BLTU/BGEU give SLTU (3). `branch`=1, `reg_we`=0.
- `reg_we`=1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL and JALR. `reg_we` is forced to 0 when `rd`==0.
- Any other opcode, or any funct7 not allowed for its funct3, sets `illegal`=1. On an illegal instruction `reg_we`, `mem_re`, `mem_we`, `branch` and `jump` are all 0 and `alucon` is 0.
- A transfer happens on an edge where valid and ready are both 1. Bundle fields are stable while `out_valid`=1 and `out_ready`=0.
- `flush`=1: every held entry is invalidated at the next edge. `in_ready` is still honoured, but the input is dropped that cycle. Flush has priority over a simultaneous accept.

## Timing
- Latency: an instruction accepted at edge N is presented with `out_valid`=1 after edge N.
- Throughput: one instruction per cycle with `out_ready` held at 1.
- Reset, asynchronous: `out_valid`=0 and every bundle output is 0, except `src1_sel`/`src2_sel`, which take `RESET_PC_SEL`. `in_ready`=1 from the first edge after `rst_n` rises. Asserting `rst_n` low mid-stream drops any held entry immediately.
- Without the skid option: `in_ready = !out_valid || out_ready`. This is a combinational path from `out_ready`.

## Configuration
- `ALU_DEC_SKID_EN` defined:
  - Two-entry skid buffer. `in_ready` comes directly from a flop, so there is no combinational `out_ready`→`in_ready` path.
  - When full, `in_ready`=0. It returns to 1 one cycle after an output transfer.
  - When empty, latency is still 1 cycle.
- `ALU_DEC_SKID_EN` undefined: a single output register and the combinational `in_ready` described in Timing.

## Structure
- Shared package `rv_pkg`:
  - `alucon` localparams (ALU_ADD=0 … ALU_SRA=13).
  - Opcode constants.
  - `src1_sel` encoding.
  - Immediate-format enum.
- Sub-module `rv_decode_comb`: the purely combinational instruction→bundle decode. The top level holds the handshake and storage.

## Test plan
- ADD and SRAI:
  - `add x3,x1,x2` (0x002081B3), `out_ready`=1 → next cycle `alucon`=0, `rd`=3, `reg_we`=1, `src2_sel`=0.
  - `srai x5,x6,4` (0x40435293) → `alucon`=13, `imm`=0x00000404, `src2_sel`=1.
- ADDI with all-ones immediate: `addi x1,x0,-1` (0xFFF00093) → `alucon`=0 (not SUB), `imm`=0xFFFFFFFF.
- BLTU: `bltu x1,x2,+8` → `alucon`=3, `branch`=1, `reg_we`=0, `imm`=0x00000008.
- Backpressure:
  - Stream 4 instructions with `out_ready`=0 for 3 cycles → held bundle stable, nothing lost or duplicated, output order preserved.
  - With `ALU_DEC_SKID_EN`: 2 instructions accepted, then `in_ready`=0.
- Flush:
  - Flush asserted while stalled and full → `out_valid`=0 after the next edge.
  - Flush asserted in the same cycle as an accepted instruction → that instruction never appears at the output.
- Illegal and reset:
  - 0x00000000 → `illegal`=1 and all write strobes 0.
  - `rst_n` pulsed low mid-stall → `out_valid` drops immediately.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: ALU op codes, opcodes, operand selects,
// immediate formats and the decoded bundle carried by alu_op_decoder.
package rv_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SLL  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_SUB  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd13;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRC1_RS1  = 2'd0;
  localparam logic [1:0] SRC1_PC   = 2'd1;
  localparam logic [1:0] SRC1_ZERO = 2'd2;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  typedef struct packed {
    logic [3:0]  alucon;
    logic [31:0] imm;
    logic [1:0]  src1_sel;
    logic        src2_sel;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        branch;
    logic        jump;
    logic        illegal;
  } bundle_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] i, input imm_fmt_e f);
    case (f)
      IMM_I:   gen_imm = {{20{i[31]}}, i[31:20]};
      IMM_S:   gen_imm = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   gen_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   gen_imm = {i[31:12], 12'b0};
      IMM_J:   gen_imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: gen_imm = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decoder_if.sv
// Fetch-side and execute-side handshake plus the decoded bundle.
interface alu_op_decoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alucon;
  logic [31:0] imm;
  logic [1:0]  src1_sel;
  logic        src2_sel;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] pc_out;
  logic        reg_we;
  logic        mem_re;
  logic        mem_we;
  logic        branch;
  logic        jump;
  logic        illegal;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, alucon, imm, src1_sel, src2_sel, rs1, rs2, rd,
           pc_out, reg_we, mem_re, mem_we, branch, jump, illegal
  );
  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, alucon, imm, src1_sel, src2_sel, rs1, rs2, rd,
           pc_out, reg_we, mem_re, mem_we, branch, jump, illegal
  );
endinterface

// File: rtl/rv_decode_comb.sv
// Purely combinational RV32I instruction -> decoded bundle.
module rv_decode_comb
  import rv_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output bundle_t     dec
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  imm_fmt_e   fmt;
  logic       legal;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  always_comb begin
    dec          = '0;
    fmt          = IMM_NONE;
    legal        = 1'b1;
    dec.rs1      = instr[19:15];
    dec.rs2      = instr[24:20];
    dec.rd       = instr[11:7];
    dec.pc       = pc;
    dec.src1_sel = SRC1_RS1;
    case (opc)
      OPC_OP: begin
        dec.alucon = {f7[5], f3};
        dec.reg_we = 1'b1;
        legal      = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      end
      OPC_OPIMM: begin
        fmt          = IMM_I;
        dec.src2_sel = 1'b1;
        // only shifts carry funct7; ADDI with imm[10] set must stay ADD
        dec.alucon   = {(f3 == 3'd5) & f7[5], f3};
        dec.reg_we   = 1'b1;
        if (f3 == 3'd1)      legal = (f7 == 7'h00);
        else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
      end
      OPC_LOAD:  begin fmt = IMM_I; dec.src2_sel = 1'b1; dec.mem_re = 1'b1; dec.reg_we = 1'b1; end
      OPC_STORE: begin fmt = IMM_S; dec.src2_sel = 1'b1; dec.mem_we = 1'b1; end
      OPC_JALR:  begin fmt = IMM_I; dec.src2_sel = 1'b1; dec.jump = 1'b1; dec.reg_we = 1'b1; end
      OPC_JAL: begin
        fmt = IMM_J; dec.src1_sel = SRC1_PC; dec.src2_sel = 1'b1; dec.jump = 1'b1; dec.reg_we = 1'b1;
      end
      OPC_AUIPC: begin fmt = IMM_U; dec.src1_sel = SRC1_PC;   dec.src2_sel = 1'b1; dec.reg_we = 1'b1; end
      OPC_LUI:   begin fmt = IMM_U; dec.src1_sel = SRC1_ZERO; dec.src2_sel = 1'b1; dec.reg_we = 1'b1; end
      OPC_BRANCH: begin
        fmt        = IMM_B;
        dec.branch = 1'b1;
        case (f3[2:1])
          2'b10:   dec.alucon = ALU_SLT;
          2'b11:   dec.alucon = ALU_SLTU;
          default: dec.alucon = ALU_SUB;
        endcase
      end
      default: legal = 1'b0;
    endcase
    dec.imm = gen_imm(instr, fmt);
    if (dec.rd == 5'd0) dec.reg_we = 1'b0;
    if (!legal) begin
      dec.alucon  = ALU_ADD;
      dec.reg_we  = 1'b0;
      dec.mem_re  = 1'b0;
      dec.mem_we  = 1'b0;
      dec.branch  = 1'b0;
      dec.jump    = 1'b0;
      dec.illegal = 1'b1;
    end
  end
endmodule

// File: rtl/alu_op_decoder.sv
// Registered decode stage with valid/ready on both sides and flush.
// ALU_DEC_SKID_EN selects a 2-entry skid buffer with a flopped in_ready.
module alu_op_decoder
  import rv_pkg::*;
#(
  parameter logic [1:0] RESET_PC_SEL = 2'd0
) (
  input logic           clk,
  input logic           rst_n,
  alu_op_decoder_if.slave bus
);
  bundle_t dec, out_b, rst_b;
  logic    out_valid;

  rv_decode_comb u_dec (.instr(bus.in_instr), .pc(bus.in_pc), .dec(dec));

  always_comb begin
    rst_b          = '0;
    rst_b.src1_sel = RESET_PC_SEL;
    rst_b.src2_sel = RESET_PC_SEL[0];
  end

`ifdef ALU_DEC_SKID_EN
  bundle_t    q0, q1;
  logic [1:0] cnt, cnt_nxt;
  logic       in_rdy_q, push, pop, wr_hi;

  assign push    = bus.in_valid && in_rdy_q && !bus.flush;
  assign pop     = (cnt != 2'd0) && bus.out_ready;
  assign cnt_nxt = cnt + 2'(push) - 2'(pop);
  assign wr_hi   = (cnt == 2'd1) && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 2'd0;
      in_rdy_q <= 1'b0;
      q0       <= rst_b;
      q1       <= rst_b;
    end else if (bus.flush) begin
      cnt      <= 2'd0;
      in_rdy_q <= 1'b1;
    end else begin
      cnt      <= cnt_nxt;
      in_rdy_q <= (cnt_nxt != 2'd2);
      if (pop && cnt == 2'd2) q0 <= q1;
      // a write into slot 0 overrides the shift above when both happen
      if (push) begin
        if (wr_hi) q1 <= dec;
        else       q0 <= dec;
      end
    end
  end

  assign out_b        = q0;
  assign out_valid    = (cnt != 2'd0);
  assign bus.in_ready = in_rdy_q;
`else
  bundle_t r;
  logic    vld, rdy_en;

  assign bus.in_ready = rdy_en && (!vld || bus.out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld    <= 1'b0;
      rdy_en <= 1'b0;
      r      <= rst_b;
    end else begin
      rdy_en <= 1'b1;
      if (bus.flush) vld <= 1'b0;
      else if (bus.in_valid && bus.in_ready) begin
        r   <= dec;
        vld <= 1'b1;
      end else if (bus.out_ready) vld <= 1'b0;
    end
  end

  assign out_b     = r;
  assign out_valid = vld;
`endif

  assign bus.out_valid = out_valid;
  assign bus.alucon    = out_b.alucon;
  assign bus.imm       = out_b.imm;
  assign bus.src1_sel  = out_b.src1_sel;
  assign bus.src2_sel  = out_b.src2_sel;
  assign bus.rs1       = out_b.rs1;
  assign bus.rs2       = out_b.rs2;
  assign bus.rd        = out_b.rd;
  assign bus.pc_out    = out_b.pc;
  assign bus.reg_we    = out_b.reg_we;
  assign bus.mem_re    = out_b.mem_re;
  assign bus.mem_we    = out_b.mem_we;
  assign bus.branch    = out_b.branch;
  assign bus.jump      = out_b.jump;
  assign bus.illegal   = out_b.illegal;
endmodule
